// File: rtl/encoder_32_5_pkg.sv
// encoder_32_5_pkg: shared widths, vector types and a one-hot helper for the request encoder.
package encoder_pkg;
  localparam int N_REQ = 32;
  localparam int IDX_W = $clog2(N_REQ);
  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;
  function automatic req_vec_t onehot(idx_t i);
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction
endpackage

// File: rtl/encoder_32_5_if.sv
// encoder_32_5_if: request lines in, encoded index out over valid/ready.
interface encoder_32_5_if;
  import encoder_pkg::*;
  req_vec_t req;
  req_vec_t pending;
  logic flush;
  logic ready;
  logic valid;
  idx_t idx;
  modport slave (input req, flush, ready, output idx, valid, pending);
  modport master (output req, flush, ready, input idx, valid, pending);
endinterface

// File: rtl/encoder_32_5_ffs.sv
// find_first_set: first set bit of vec at or after start, wrapping past the top index.
module find_first_set
  import encoder_pkg::*;
(
  input  req_vec_t vec,
  input  idx_t     start,
  output idx_t     pos,
  output logic     found
);
  idx_t j;
  always_comb begin
    pos = '0;
    found = 1'b0;
    j = '0;
    // descending scan so the smallest offset from start is written last
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = start + idx_t'(i);
      if (vec[j]) begin
        pos = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/encoder_32_5.sv
// encoder_32_5: sticky 32-line request collector presenting one 5-bit index per transfer.
// Define ENCODER_ROUND_ROBIN_EN for rotating priority; default is lowest-index-first.
module encoder_32_5
  import encoder_pkg::*;
(
  input logic clk,
  input logic rst_n,
  encoder_32_5_if.slave bus
);
  idx_t     idx_q, idx_d, start, pos;
  logic     valid_q, valid_d, found, accept, load;
  req_vec_t pending_q, pending_d, cand;
`ifdef ENCODER_ROUND_ROBIN_EN
  idx_t ptr_q, ptr_d;
  assign start = ptr_q + idx_t'(1);
  assign ptr_d = (!bus.flush && accept) ? idx_q : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= idx_t'(N_REQ - 1);
    else ptr_q <= ptr_d;
`else
  assign start = '0;
`endif
  find_first_set u_ffs (.vec(cand), .start(start), .pos(pos), .found(found));
  always_comb begin
    accept = valid_q && bus.ready;
    load = !valid_q || accept;
    cand = (bus.pending | bus.req) & ~(accept ? onehot(idx_q) : '0);
    idx_d = (!bus.flush && load && found) ? pos : idx_q;
    valid_d = !bus.flush && (load ? found : valid_q);
    // the presented index never sits in pending, whether stalled or just accepted
    pending_d = bus.flush ? '0 :
                cand & ~(valid_q ? onehot(idx_q) : '0) & ~((load && found) ? onehot(pos) : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx_q <= '0;
      valid_q <= 1'b0;
      pending_q <= '0;
    end else begin
      idx_q <= idx_d;
      valid_q <= valid_d;
      pending_q <= pending_d;
    end
  assign bus.idx = idx_q;
  assign bus.valid = valid_q;
  assign bus.pending = pending_q;
endmodule
